mdu_unit: RTL and testbench
===========================

Name: mdu_unit

Overview:
- Multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Consumes the forwarded rs/rt values read from the register file.
- Owns the HI/LO registers.
- Supplies `mfhi`/`mflo` data that travels down the pipeline to the register-file write port.
- Models multi-cycle latency and exposes a busy flag that the hazard unit uses to stall dependent MDU instructions in D.

Parameters:
- MULT_CYCLES, 5, cycles busy is held after a mult/multu start
- DIV_CYCLES, 10, cycles busy is held after a div/divu start

Ports:
- clk      input   1   system clock, rising edge
- reset    input   1   asynchronous, active-high; clears all state
- en       input   1   E-stage instruction is valid (not bubble/flushed); gates all state changes
- mdu_op   input   4   0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9-15 treated as NONE
- rs_val   input   32  forwarded rs operand
- rt_val   input   32  forwarded rt operand
- start    output  1   combinational: en && idle && mdu_op in {1..4}
- busy     output  1   registered: operation in flight
- rd_data  output  32  combinational: HI when mdu_op==MFHI, LO when MFLO, else 0

Behaviour:
- Reset (async, immediate, no clock edge needed): HI=0, LO=0, counter=0, busy=0, shadow results=0.
- State: idle (counter==0) / running (counter>0). busy = (counter != 0).
- Start on the rising edge where start==1:
  - Capture result into shadow_hi/shadow_lo from the current rs_val/rt_val.
  - Load counter with MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4); busy goes 1 after this edge.
  - Later operand changes do not affect the result.
- Running: counter decrements each edge. On the edge where counter goes 1→0, HI<=shadow_hi, LO<=shadow_lo, busy->0 on the same edge.
  - busy is high for exactly N consecutive cycles.
  - New HI/LO are visible on rd_data in the first cycle busy is low.
- Arithmetic:
  - MULT: signed 32x32→64, {HI,LO}=product.
  - MULTU: unsigned 32x32→64, {HI,LO}=product.
  - DIV: signed; LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - DIVU: unsigned; LO=quotient, HI=remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (rt_val==0): latency unchanged; HI/LO are NOT modified at completion.
- MTHI/MTLO: when en && idle, HI (or LO) <= rs_val at the next edge. Ignored while busy.
- MFHI/MFLO: pure read of current HI/LO; no state change. When busy, returns the old value.
- Any start or MT* op arriving while busy is ignored; state is unaffected. The hazard unit guarantees this does not occur in legal operation.
- en==0: no state change of any kind. The in-flight counter still runs.
- Reset mid-operation aborts the operation. The pending result is discarded and HI/LO read 0.
- Back-to-back operation: a new start is accepted in the cycle busy first reads 0.

Test Plan:
- MULT, rs=0xFFFFFFFE, rt=3, en=1 → busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MFHI during busy returns the old HI (0).
- MULTU, same operands → HI=0x00000002, LO=0xFFFFFFFA. Changing rs/rt during busy has no effect on the result.
- DIV, rs=0xFFFFFFF9 (-7), rt=2 → busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIVU 7/2 started in the first idle cycle → LO=3, HI=1.
- MTHI rs=0x12345678, then MFHI next cycle → rd_data=0x12345678. MTLO while a MULT is busy → LO ends with the MULT result, not the MTLO value.
- DIV with rt=0 after HI=0xA, LO=0xB → busy 10 cycles, HI/LO remain 0xA/0xB. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- Assert reset asynchronously 2 cycles into a DIV, between clock edges → busy, HI, LO read 0 before the next edge. No update after reset release. en=0 with MULT → start=0, no busy.

Source files
------------

// File: rtl/mdu_unit.sv
// mdu_unit: E-stage multiply/divide unit for the 5-stage MIPS pipeline.
// Owns HI/LO. The result of a mult/div is computed and parked in shadow
// registers at the start edge. It is committed to HI/LO when the latency
// counter expires. busy lets the hazard unit stall dependent MDU ops in D.
module mdu_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        start,
  output logic        busy,
  output logic [31:0] rd_data
);

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int          CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);

  // Architectural and in-flight state.
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_shadow_hi;
  logic [31:0]      r_shadow_lo;
  logic [CNT_W-1:0] r_count;
  logic             r_skip_commit;

  // Decode.
  logic w_idle;
  logic w_is_mul;
  logic w_is_div;
  logic w_signed_mul;
  logic w_signed_div;
  logic w_rt_zero;
  logic w_done;
  logic w_mthi;
  logic w_mtlo;

  assign w_idle       = (r_count == '0);
  assign w_is_mul     = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU);
  assign w_is_div     = (mdu_op == OP_DIV)  || (mdu_op == OP_DIVU);
  assign w_signed_mul = (mdu_op == OP_MULT);
  assign w_signed_div = (mdu_op == OP_DIV);
  assign w_rt_zero    = (rt_val == 32'd0);
  assign w_done       = (r_count == CNT_ONE);
  assign w_mthi       = en && w_idle && (mdu_op == OP_MTHI);
  assign w_mtlo       = en && w_idle && (mdu_op == OP_MTLO);

  assign start = en && w_idle && (w_is_mul || w_is_div);
  assign busy  = !w_idle;

  // Multiplier: sign- or zero-extend to 64 bits; the low 64 bits of the
  // product are the correct two's-complement result in both cases.
  logic [63:0] w_mul_a;
  logic [63:0] w_mul_b;
  logic [63:0] w_product;

  assign w_mul_a   = {{32{rs_val[31] & w_signed_mul}}, rs_val};
  assign w_mul_b   = {{32{rt_val[31] & w_signed_mul}}, rt_val};
  assign w_product = w_mul_a * w_mul_b;

  // Divider: divide magnitudes, then restore signs. Working on magnitudes
  // makes 0x80000000 / -1 wrap naturally to quotient 0x80000000, remainder 0.
  logic        w_rs_neg;
  logic        w_rt_neg;
  logic [31:0] w_dvd_mag;
  logic [31:0] w_dvs_mag;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  assign w_rs_neg  = w_signed_div && rs_val[31];
  assign w_rt_neg  = w_signed_div && rt_val[31];
  assign w_dvd_mag = w_rs_neg ? (32'd0 - rs_val) : rs_val;
  // A zero divisor is replaced by 1 only to keep the divider defined; the
  // result is thrown away at commit time.
  assign w_dvs_mag = w_rt_zero ? 32'd1 : (w_rt_neg ? (32'd0 - rt_val) : rt_val);
  assign w_q_mag   = w_dvd_mag / w_dvs_mag;
  assign w_r_mag   = w_dvd_mag % w_dvs_mag;
  assign w_quot    = (w_rs_neg ^ w_rt_neg) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_rem     = w_rs_neg ? (32'd0 - w_r_mag) : w_r_mag;

  // Latency counter: load on start, count down to zero while running.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (start) begin
      r_count <= w_is_mul ? CNT_MULT : CNT_DIV;
    end else if (!w_idle) begin
      r_count <= r_count - CNT_ONE;
    end
  end

  // Shadow result capture at the start edge; later operand changes are ignored.
  // NOTE: shadows are reset too, so an aborted operation cannot leak a stale result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shadow_hi   <= 32'd0;
      r_shadow_lo   <= 32'd0;
      r_skip_commit <= 1'b0;
    end else if (start) begin
      if (w_is_mul) begin
        r_shadow_hi <= w_product[63:32];
        r_shadow_lo <= w_product[31:0];
      end else begin
        r_shadow_hi <= w_rem;
        r_shadow_lo <= w_quot;
      end
      r_skip_commit <= w_is_div && w_rt_zero;
    end
  end

  // HI/LO update: commit on the final busy edge, or MTHI/MTLO while idle.
  // The two sources are exclusive because commit happens only when busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (w_done) begin
      if (!r_skip_commit) begin
        r_hi <= r_shadow_hi;
        r_lo <= r_shadow_lo;
      end
    end else begin
      if (w_mthi) r_hi <= rs_val;
      if (w_mtlo) r_lo <= rs_val;
    end
  end

  // MFHI/MFLO read path; other ops read zero.
  // NOTE: the default assignment first keeps this combinational block latch-free.
  always_comb begin
    rd_data = 32'd0;
    case (mdu_op)
      OP_MFHI: rd_data = r_hi;
      OP_MFLO: rd_data = r_lo;
      OP_NONE: rd_data = 32'd0;
      default: rd_data = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: scoreboard bench for mdu_unit. Expected HI/LO come from a
// behavioural model, are queued when an op starts and are compared once
// busy drops.
module tb_mdu_unit;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [3:0]  mdu_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        start;
  logic        busy;
  logic [31:0] rd_data;

  int   err_cnt = 0;
  int   chk_cnt = 0;
  res_t sb[$];
  logic [31:0] m_hi, m_lo;       // model HI/LO after all queued ops complete
  logic [31:0] prev_hi, prev_lo; // model HI/LO before the op in flight

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .en(en), .mdu_op(mdu_op),
    .rs_val(rs_val), .rt_val(rt_val),
    .start(start), .busy(busy), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model returning {HI,LO} after the op; cur is the current {HI,LO}.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] cur);
    longint          sa, sb_, sq, sr;
    longint unsigned ua, ub;
    logic [63:0]     res;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    res = cur;
    case (op)
      OP_MULT:  res = sa * sb_;
      OP_MULTU: res = ua * ub;
      OP_DIV:   if (b != 0) begin
                  sq  = sa / sb_;
                  sr  = sa % sb_;
                  res = {sr[31:0], sq[31:0]};
                end
      OP_DIVU:  if (b != 0) res = {32'(ua % ub), 32'(ua / ub)};
      default:  res = cur;
    endcase
    return res;
  endfunction

  // Read HI then LO through rd_data; consumes 2 time units of the low phase.
  task automatic read_hi_lo(output logic [31:0] h, output logic [31:0] l);
    mdu_op = OP_MFHI; #1 h = rd_data;
    mdu_op = OP_MFLO; #1 l = rd_data;
    mdu_op = OP_NONE;
  endtask

  // Issue a mult/div in the low phase; expect start, queue the model result.
  task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string tag);
    logic [63:0] r;
    en = 1'b1; mdu_op = op; rs_val = a; rt_val = b;
    #1 check({tag, "_start"}, 64'(start), 64'd1);
    prev_hi = m_hi; prev_lo = m_lo;
    r = model(op, a, b, {m_hi, m_lo});
    sb.push_back(r);
    m_hi = r[63:32]; m_lo = r[31:0];
    @(posedge clk);
    #1 mdu_op = OP_NONE;
  endtask

  // Count busy cycles (bounded), poke the DUT while busy, then pop and compare.
  task automatic wait_done(input int n, input bit intrude, input string tag);
    int          cnt;
    bit          done;
    logic [31:0] h, l;
    res_t        e;
    cnt = 0; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      #1;
      if (busy) begin
        cnt++;
        if (cnt == 1) begin
          read_hi_lo(h, l);
          check({tag, "_old_hi"}, {32'd0, h}, {32'd0, prev_hi});
          check({tag, "_old_lo"}, {32'd0, l}, {32'd0, prev_lo});
        end
        if (intrude && cnt == 2) begin
          mdu_op = OP_MTLO; rs_val = 32'hDEADBEEF;
          #1 check({tag, "_mtlo_busy_start"}, 64'(start), 64'd0);
          mdu_op = OP_NONE;
        end
        if (intrude && cnt == 3) begin
          mdu_op = OP_DIV; rs_val = 32'd99; rt_val = 32'd5;
          #1 check({tag, "_div_busy_start"}, 64'(start), 64'd0);
          mdu_op = OP_NONE;
        end
        rs_val = $urandom; rt_val = $urandom;
      end else begin
        done = 1'b1;
      end
    end
    check({tag, "_busy_cycles"}, 64'(cnt), 64'(n));
    if (done) begin
      read_hi_lo(h, l);
      if (sb.size() == 0) begin
        check({tag, "_sb_underflow"}, 64'd0, 64'd1);
      end else begin
        e = sb.pop_front();
        check({tag, "_hi"}, {32'd0, h}, {32'd0, e.hi});
        check({tag, "_lo"}, {32'd0, l}, {32'd0, e.lo});
      end
    end
  endtask

  // MTHI/MTLO issued in the low phase; returns in the next low phase.
  task automatic mt_op(input logic [3:0] op, input logic [31:0] v);
    en = 1'b1; mdu_op = op; rs_val = v;
    @(posedge clk);
    #1 mdu_op = OP_NONE;
    @(negedge clk);
    if (op == OP_MTHI) m_hi = v;
    else               m_lo = v;
  endtask

  task automatic check_hi_lo(input string tag);
    logic [31:0] h, l;
    read_hi_lo(h, l);
    check({tag, "_hi"}, {32'd0, h}, {32'd0, m_hi});
    check({tag, "_lo"}, {32'd0, l}, {32'd0, m_lo});
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; mdu_op = OP_NONE; rs_val = '0; rt_val = '0;
    m_hi = '0; m_lo = '0; prev_hi = '0; prev_lo = '0;
    #1 check("rst_busy", 64'(busy), 64'd0);
    check("rst_start", 64'(start), 64'd0);
    check_hi_lo("rst");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Signed and unsigned multiply; operands scrambled while busy.
    start_op(OP_MULT, 32'hFFFFFFFE, 32'd3, "mult");
    wait_done(5, 1'b0, "mult");
    start_op(OP_MULTU, 32'hFFFFFFFE, 32'd3, "multu");
    wait_done(5, 1'b0, "multu");

    // Signed divide, then DIVU started in the first idle cycle.
    start_op(OP_DIV, 32'hFFFFFFF9, 32'd2, "div");
    wait_done(10, 1'b0, "div");
    start_op(OP_DIVU, 32'd7, 32'd2, "divu_b2b");
    wait_done(10, 1'b0, "divu_b2b");

    // MTHI followed by MFHI in the next cycle.
    mt_op(OP_MTHI, 32'h12345678);
    check_hi_lo("mthi");

    // MTLO and a second start both attempted while a MULT is busy.
    start_op(OP_MULT, 32'h00012345, 32'h00000010, "mult_mt");
    wait_done(5, 1'b1, "mult_mt");

    // Divide by zero leaves HI/LO untouched.
    mt_op(OP_MTHI, 32'h0000000A);
    mt_op(OP_MTLO, 32'h0000000B);
    check_hi_lo("mt_ab");
    start_op(OP_DIV, 32'd1234, 32'd0, "div0");
    wait_done(10, 1'b0, "div0");

    // Overflow case of signed divide.
    start_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
    wait_done(10, 1'b0, "div_ovf");

    // en low: a MULT request must neither start nor set busy.
    en = 1'b0; mdu_op = OP_MULT; rs_val = 32'd3; rt_val = 32'd4;
    #1 check("en0_start", 64'(start), 64'd0);
    @(negedge clk);
    #1 check("en0_busy", 64'(busy), 64'd0);
    mdu_op = OP_NONE; en = 1'b1;
    check_hi_lo("en0");
    @(negedge clk);

    // Asynchronous reset two cycles into a DIV, between clock edges.
    start_op(OP_DIV, 32'd100, 32'd7, "div_rst");
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    sb.delete();
    m_hi = '0; m_lo = '0;
    #1 check("arst_busy", 64'(busy), 64'd0);
    check_hi_lo("arst");
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    #1 check("post_rst_busy", 64'(busy), 64'd0);
    check_hi_lo("post_rst");

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
